half_cycle_sequencer: RTL and testbench



---
 rtl/half_cycle_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_half_cycle_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/half_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// half_cycle_sequencer
//
// Control sequencer for a core that executes each 32-bit instruction as two
// 16-bit halves. Every instruction runs FETCH -> DECODE -> EXE_H0 -> EXE_H1,
// then an optional MEM_WAIT, then RETIRE. The half order (lower half first or
// upper half first) is captured in DECODE. A load/store waits in MEM_WAIT for
// dmem_ack. If the ack does not arrive within MEM_TIMEOUT cycles, the sticky
// bus_err flag is set and the instruction is retired anyway.
//
// Parameters
//   MEM_TIMEOUT  maximum MEM_WAIT cycles before a bus error (1..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          core clock, rising edge
//   rst          asynchronous active-high reset
//   run          level enable; a new instruction starts only while high
//   imem_ack     instruction word valid, completes FETCH
//   ser_start    first half from decode (0 = lower, 1 = upper), used in DECODE
//   mem_op       instruction is a load/store, sampled in EXE_H1
//   dmem_ack     data access complete, observed only in MEM_WAIT
//   imem_req     fetch request (FETCH)
//   first_cycle  decode strobe (DECODE)
//   half_sel     half being executed (0 = lower, 1 = upper), else 0
//   exe_valid    an execute half-cycle is active
//   dmem_req     data memory request (MEM_WAIT)
//   pc_en        PC / register-file commit strobe (RETIRE)
//   retired      retired-instruction count, wraps silently
//   bus_err      sticky data-memory timeout flag
//   busy         state is not IDLE
// -----------------------------------------------------------------------------
module half_cycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             ser_start,
  input  logic             mem_op,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             first_cycle,
  output logic             half_sel,
  output logic             exe_valid,
  output logic             dmem_req,
  output logic             pc_en,
  output logic [CNT_W-1:0] retired,
  output logic             bus_err,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXE_H0   = 3'd3,
    S_EXE_H1   = 3'd4,
    S_MEM_WAIT = 3'd5,
    S_RETIRE   = 3'd6
  } state_t;

  // The wait counter holds the number of MEM_WAIT cycles already spent
  // without an ack. When it reaches MEM_TIMEOUT-1 at the start of a cycle,
  // this is the last allowed cycle: no ack in this cycle means a timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             order_q, order_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             bus_err_q, bus_err_d;
  logic             timeout_s;

  assign timeout_s = (wait_q == WAIT_LAST);

  // State and datapath registers, asynchronously cleared by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      order_q   <= 1'b0;
      wait_q    <= 8'd0;
      retired_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      order_q   <= order_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state logic, half-order capture, wait counter, retire count and error flag.
  always_comb begin
    state_d   = state_q;
    order_d   = order_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        order_d = ser_start;
        state_d = S_EXE_H0;
      end
      S_EXE_H0: begin
        state_d = S_EXE_H1;
      end
      S_EXE_H1: begin
        if (mem_op) begin
          wait_d  = 8'd0;
          state_d = S_MEM_WAIT;
        end else begin
          state_d = S_RETIRE;
        end
      end
      S_MEM_WAIT: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (dmem_ack) begin
          state_d = S_RETIRE;
        end else if (timeout_s) begin
          bus_err_d = 1'b1;
          state_d   = S_RETIRE;
        end else begin
          wait_d  = wait_q + 8'd1;
          state_d = S_MEM_WAIT;
        end
      end
      S_RETIRE: begin
        retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    imem_req    = 1'b0;
    first_cycle = 1'b0;
    half_sel    = 1'b0;
    exe_valid   = 1'b0;
    dmem_req    = 1'b0;
    pc_en       = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_FETCH:    imem_req    = 1'b1;
      S_DECODE:   first_cycle = 1'b1;
      S_EXE_H0: begin
        exe_valid = 1'b1;
        half_sel  = order_q;
      end
      S_EXE_H1: begin
        exe_valid = 1'b1;
        half_sel  = ~order_q;
      end
      S_MEM_WAIT: dmem_req    = 1'b1;
      S_RETIRE:   pc_en       = 1'b1;
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign retired = retired_q;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_half_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for half_cycle_sequencer, built with MEM_TIMEOUT=4 and CNT_W=4 so that
// the timeout and counter-wrap cases stay short. A table of per-cycle vectors
// drives several instructions back to back. Hand-written sequences cover reset
// in MEM_WAIT, the first fetch after reset, and counter wrap.
// -----------------------------------------------------------------------------
module tb_half_cycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, imem_ack, ser_start, mem_op, dmem_ack;
  logic       imem_req, first_cycle, half_sel, exe_valid, dmem_req, pc_en, bus_err, busy;
  logic [3:0] retired;

  int n_tests = 0;
  int n_fail  = 0;

  half_cycle_sequencer #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .ser_start(ser_start),
    .mem_op(mem_op), .dmem_ack(dmem_ack), .imem_req(imem_req),
    .first_cycle(first_cycle), .half_sel(half_sel), .exe_valid(exe_valid),
    .dmem_req(dmem_req), .pc_en(pc_en), .retired(retired), .bus_err(bus_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Output bundle {imem_req, first_cycle, half_sel, exe_valid, dmem_req, pc_en, busy}.
  localparam logic [6:0] O_IDLE = 7'b0000000;
  localparam logic [6:0] O_FET  = 7'b1000001;
  localparam logic [6:0] O_DEC  = 7'b0100001;
  localparam logic [6:0] O_EXL  = 7'b0001001;
  localparam logic [6:0] O_EXU  = 7'b0011001;
  localparam logic [6:0] O_MEM  = 7'b0000101;
  localparam logic [6:0] O_RET  = 7'b0000011;

  // Input bundle {run, imem_ack, ser_start, mem_op, dmem_ack}.
  typedef struct {
    logic [4:0] in;
    logic [6:0] exp_o;
    logic       exp_err;
    logic [3:0] exp_ret;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] outs();
    return {imem_req, first_cycle, half_sel, exe_valid, dmem_req, pc_en, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    {run, imem_ack, ser_start, mem_op, dmem_ack} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [4:0] in, input logic [6:0] o, input logic e, input logic [3:0] r);
    vec_t v;
    v.in = in; v.exp_o = o; v.exp_err = e; v.exp_ret = r;
    vecs.push_back(v);
  endtask

  initial begin
    // Instruction 1: register-only, lower half first.
    add(5'b11000, O_FET,  1'b0, 4'd0);
    add(5'b11000, O_DEC,  1'b0, 4'd0);
    add(5'b10000, O_EXL,  1'b0, 4'd0);
    add(5'b10000, O_EXU,  1'b0, 4'd0);
    add(5'b10000, O_RET,  1'b0, 4'd0);
    // Instruction 2: fetch stall, upper half first; ser_start outside DECODE ignored.
    add(5'b10000, O_FET,  1'b0, 4'd1);
    add(5'b10100, O_FET,  1'b0, 4'd1);
    add(5'b11000, O_DEC,  1'b0, 4'd1);
    add(5'b10100, O_EXU,  1'b0, 4'd1);
    add(5'b10000, O_EXL,  1'b0, 4'd1);
    add(5'b10000, O_RET,  1'b0, 4'd1);
    // Instruction 3: load, ack in the 4th MEM_WAIT cycle (same cycle as timeout).
    add(5'b11001, O_FET,  1'b0, 4'd2);
    add(5'b11000, O_DEC,  1'b0, 4'd2);
    add(5'b10010, O_EXL,  1'b0, 4'd2);
    add(5'b10010, O_EXU,  1'b0, 4'd2);
    add(5'b10010, O_MEM,  1'b0, 4'd2);
    add(5'b10000, O_MEM,  1'b0, 4'd2);
    add(5'b10000, O_MEM,  1'b0, 4'd2);
    add(5'b10000, O_MEM,  1'b0, 4'd2);
    add(5'b10001, O_RET,  1'b0, 4'd2);
    // Instruction 4: store that times out; run drops in the last MEM_WAIT cycle.
    add(5'b11000, O_FET,  1'b0, 4'd3);
    add(5'b11000, O_DEC,  1'b0, 4'd3);
    add(5'b10000, O_EXL,  1'b0, 4'd3);
    add(5'b10000, O_EXU,  1'b0, 4'd3);
    add(5'b10010, O_MEM,  1'b0, 4'd3);
    add(5'b10000, O_MEM,  1'b0, 4'd3);
    add(5'b10000, O_MEM,  1'b0, 4'd3);
    add(5'b10000, O_MEM,  1'b0, 4'd3);
    add(5'b00000, O_RET,  1'b1, 4'd3);
    add(5'b01000, O_IDLE, 1'b1, 4'd4);
    add(5'b00000, O_IDLE, 1'b1, 4'd4);
    // Instruction 5: run dropped right after fetch; completes, bus_err stays set.
    add(5'b11000, O_FET,  1'b1, 4'd4);
    add(5'b01000, O_DEC,  1'b1, 4'd4);
    add(5'b00000, O_EXL,  1'b1, 4'd4);
    add(5'b00000, O_EXU,  1'b1, 4'd4);
    add(5'b00000, O_RET,  1'b1, 4'd4);
    add(5'b00000, O_IDLE, 1'b1, 4'd5);

    // Reset state.
    drive(5'b00000);
    rst = 1'b1;
    #1;
    check("reset_outs", 32'(outs()), 32'(O_IDLE));
    check("reset_err", 32'(bus_err), 32'd0);
    check("reset_ret", 32'(retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_after_reset", 32'(outs()), 32'(O_IDLE));

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      tick();
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d_err", i), 32'(bus_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_ret", i), 32'(retired), 32'(vecs[i].exp_ret));
    end

    // Reset while in MEM_WAIT discards the instruction immediately.
    drive(5'b11010);
    repeat (5) tick();
    check("pre_rst_mem", 32'(outs()), 32'(O_MEM));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mem_outs", 32'(outs()), 32'(O_IDLE));
    check("rst_mem_ret", 32'(retired), 32'd0);
    check("rst_mem_err", 32'(bus_err), 32'd0);
    drive(5'b00000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_idle", 32'(outs()), 32'(O_IDLE));
    check("post_rst_ret", 32'(retired), 32'd0);

    // First fetch after reset on the first edge with run=1; then 16 retires wrap the counter.
    drive(5'b11000);
    tick();
    check("first_fetch", 32'(outs()), 32'(O_FET));
    repeat (79) tick();
    check("wrap_last_ret", 32'(outs()), 32'(O_RET));
    check("wrap_pre", 32'(retired), 32'd15);
    tick();
    check("wrap_fetch", 32'(outs()), 32'(O_FET));
    check("wrap_zero", 32'(retired), 32'd0);
    check("wrap_err", 32'(bus_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
